pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 83 ++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Stage handshake bundle for pipe_ctrl: hazard/flush inputs and the
// per-stage allowin/valid outputs.
interface pipe_ctrl_if;
  logic if_ready_go;
  logic id_load_use;
  logic exe_is_div;
  logic ex_flush;
  logic eret_flush;
  logic id_allowin;
  logic exe_allowin;
  logic mem_allowin;
  logic wb_allowin;
  logic id_valid;
  logic exe_valid;
  logic mem_valid;
  logic wb_valid;
  logic if_flush;
  logic div_busy;

  modport master (
    output if_ready_go, id_load_use, exe_is_div, ex_flush, eret_flush,
    input  id_allowin, exe_allowin, mem_allowin, wb_allowin,
    input  id_valid, exe_valid, mem_valid, wb_valid, if_flush, div_busy
  );

  modport slave (
    input  if_ready_go, id_load_use, exe_is_div, ex_flush, eret_flush,
    output id_allowin, exe_allowin, mem_allowin, wb_allowin,
    output id_valid, exe_valid, mem_valid, wb_valid, if_flush, div_busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Valid/allowin control for a 5-stage pipeline with load-use bubbles and WB flush.
// Define DIV_STALL_EN to hold div/divu in EXE for DIV_LAT cycles.
module pipe_ctrl #(
  parameter int unsigned DIV_LAT = 8
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  logic flush;
  logic id_ready_go;
  logic exe_ready_go;
  logic id_allowin;
  logic exe_allowin;
  logic mem_allowin;
  logic wb_allowin;
  logic id_v;
  logic exe_v;
  logic mem_v;
  logic wb_v;

  assign flush       = bus.ex_flush | bus.eret_flush;
  assign id_ready_go = ~bus.id_load_use;

  assign wb_allowin  = ~wb_v | 1'b1;
  assign mem_allowin = ~mem_v | wb_allowin;
  assign exe_allowin = ~exe_v | (exe_ready_go & mem_allowin);
  assign id_allowin  = ~id_v  | (id_ready_go & exe_allowin);

  // A stalled ID feeding an open EXE loads exe_v with 0, which is the bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_v  <= 1'b0;
      exe_v <= 1'b0;
      mem_v <= 1'b0;
      wb_v  <= 1'b0;
    end else begin
      if (id_allowin)  id_v  <= bus.if_ready_go;
      if (exe_allowin) exe_v <= id_v & id_ready_go;
      if (mem_allowin) mem_v <= exe_v & exe_ready_go;
      if (wb_allowin)  wb_v  <= mem_v;
    end
  end

`ifdef DIV_STALL_EN
  localparam logic [4:0] DIV_MAX = 5'(DIV_LAT - 1);

  logic [4:0] div_cnt;

  assign exe_ready_go = ~bus.exe_is_div | (div_cnt == DIV_MAX);

  // Count saturates at DIV_MAX (ready_go is then 1) and holds while MEM is blocked.
  always_ff @(posedge clk) begin
    if (rst || flush || !exe_v) begin
      div_cnt <= '0;
    end else if (exe_ready_go && mem_allowin) begin
      div_cnt <= '0;
    end else if (!exe_ready_go) begin
      div_cnt <= div_cnt + 5'd1;
    end
  end

  assign bus.div_busy = exe_v & bus.exe_is_div & (div_cnt != DIV_MAX);
`else
  logic [5:0] unused_div_cfg;

  assign unused_div_cfg = {bus.exe_is_div, 5'(DIV_LAT)};
  assign exe_ready_go   = 1'b1;
  assign bus.div_busy   = 1'b0;
`endif

  assign bus.if_flush    = flush;
  assign bus.id_allowin  = id_allowin;
  assign bus.exe_allowin = exe_allowin;
  assign bus.mem_allowin = mem_allowin;
  assign bus.wb_allowin  = wb_allowin;
  assign bus.id_valid    = id_v;
  assign bus.exe_valid   = exe_v;
  assign bus.mem_valid   = mem_v;
  assign bus.wb_valid    = wb_v;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for handshake/flush behaviour,
// plus hand sequences for the divide stall (or its absence without DIV_STALL_EN).
module tb_pipe_ctrl;

  typedef struct {
    logic       rst;
    logic       irg;
    logic       lu;
    logic       dv;
    logic       exf;
    logic       erf;
    logic [9:0] exp;   // {id,exe,mem,wb valid, id,exe,mem,wb allowin, if_flush, div_busy}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;
  vec_t tbl[$];

  pipe_ctrl_if bus ();

  pipe_ctrl #(.DIV_LAT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input logic r, irg, lu, dv, exf, erf, input logic [9:0] e);
    vec_t t;
    t.rst = r; t.irg = irg; t.lu = lu; t.dv = dv; t.exf = exf; t.erf = erf; t.exp = e;
    return t;
  endfunction

  function automatic logic [9:0] outs();
    return {bus.id_valid, bus.exe_valid, bus.mem_valid, bus.wb_valid,
            bus.id_allowin, bus.exe_allowin, bus.mem_allowin, bus.wb_allowin,
            bus.if_flush, bus.div_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, irg, lu, dv, exf, erf);
    rst             = r;
    bus.if_ready_go = irg;
    bus.id_load_use = lu;
    bus.exe_is_div  = dv;
    bus.ex_flush    = exf;
    bus.eret_flush  = erf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl.push_back(v(0,1,0,0,0,0, 10'b0000_1111_00));
    tbl.push_back(v(0,1,0,0,0,0, 10'b1000_1111_00));
    tbl.push_back(v(0,1,0,0,0,0, 10'b1100_1111_00));
    tbl.push_back(v(0,1,0,0,0,0, 10'b1110_1111_00));
    tbl.push_back(v(0,1,0,0,0,0, 10'b1111_1111_00));
    tbl.push_back(v(0,1,1,0,0,0, 10'b1111_0111_00));  // load-use: ID held, bubble to EXE
    tbl.push_back(v(0,1,0,0,0,0, 10'b1011_1111_00));
    tbl.push_back(v(0,1,0,0,0,0, 10'b1101_1111_00));
    tbl.push_back(v(0,1,0,0,0,0, 10'b1110_1111_00));
    tbl.push_back(v(0,1,1,0,0,1, 10'b1111_0111_10));  // eret + load-use: flush wins
    tbl.push_back(v(0,0,0,0,0,0, 10'b0000_1111_00));
    tbl.push_back(v(0,1,0,0,1,0, 10'b0000_1111_10));
    tbl.push_back(v(0,1,0,0,0,0, 10'b0000_1111_00));
    tbl.push_back(v(0,0,0,0,0,0, 10'b1000_1111_00));
    tbl.push_back(v(1,0,1,0,0,0, 10'b0100_1111_00));
    tbl.push_back(v(0,0,1,0,0,0, 10'b0000_1111_00));
    tbl.push_back(v(0,0,0,0,0,0, 10'b0000_1111_00));

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].irg, tbl[i].lu, tbl[i].dv, tbl[i].exf, tbl[i].erf);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      tick();
    end

`ifdef DIV_STALL_EN
    // div enters EXE with a second instruction behind it in ID
    do_reset();
    bus.if_ready_go = 1'b1;
    tick();
    tick();
    bus.if_ready_go = 1'b0;
    bus.exe_is_div  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      bus.id_load_use = (c == 1);
      #2;
      chk($sformatf("div_busy_c%0d", c), 32'(bus.div_busy), 32'd1);
      chk($sformatf("div_stall_c%0d", c),
          32'({bus.id_valid, bus.exe_valid, bus.mem_valid, bus.id_allowin, bus.exe_allowin}),
          32'(5'b11000));
      tick();
    end
    bus.id_load_use = 1'b0;
    #2;
    chk("div_done_c8", 32'({bus.div_busy, bus.exe_allowin, bus.mem_valid}), 32'(3'b010));
    tick();
    bus.exe_is_div = 1'b0;
    #2;
    chk("div_in_mem", 32'({bus.id_valid, bus.exe_valid, bus.mem_valid}), 32'(3'b011));
    chk("div_cnt_clr", 32'(dut.div_cnt), 32'd0);
    tick();

    // exception flush while div_cnt == 3
    do_reset();
    bus.if_ready_go = 1'b1;
    tick();
    bus.if_ready_go = 1'b0;
    tick();
    bus.exe_is_div = 1'b1;
    tick();
    tick();
    tick();
    #2;
    chk("flush_cnt3", 32'(dut.div_cnt), 32'd3);
    bus.ex_flush = 1'b1;
    #2;
    chk("flush_if_flush", 32'(bus.if_flush), 32'd1);
    tick();
    bus.ex_flush = 1'b0;
    #2;
    chk("flush_valids", 32'(outs()), 32'(10'b0000_1111_00));
    chk("flush_cnt0", 32'(dut.div_cnt), 32'd0);
    bus.exe_is_div = 1'b0;
    tick();

    // reset mid-divide: nothing keeps counting afterwards
    do_reset();
    bus.if_ready_go = 1'b1;
    tick();
    bus.if_ready_go = 1'b0;
    tick();
    bus.exe_is_div = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("rst_div_outs", 32'(outs()), 32'(10'b0000_1111_00));
    tick();
    #2;
    chk("rst_div_cnt", 32'(dut.div_cnt), 32'd0);
    bus.exe_is_div = 1'b0;
    tick();
`else
    // divide without the stall feature passes straight through EXE
    do_reset();
    bus.if_ready_go = 1'b1;
    tick();
    bus.if_ready_go = 1'b0;
    tick();
    bus.exe_is_div = 1'b1;
    #2;
    chk("nodiv_no_stall", 32'({bus.exe_valid, bus.exe_allowin, bus.div_busy}), 32'(3'b110));
    tick();
    #2;
    chk("nodiv_in_mem", 32'({bus.exe_valid, bus.mem_valid, bus.div_busy}), 32'(3'b010));
    bus.exe_is_div = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
